// File: rtl/ecc_fau_sched_pkg.sv
// ecc_fau_sched_pkg: shared types and defaults for the FAU command sequencer.
// Optional feature macro used by the top: ECC_FAU_SCHED_CMD_FIFO_EN.
package ecc_fau_sched_pkg;

  // Command opcode as presented on cmd_op_i.
  typedef enum logic [1:0] {
    FAU_ADD = 2'd0,
    FAU_SUB = 2'd1,
    FAU_MUL = 2'd2,
    FAU_NOP = 2'd3
  } fau_op_e;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WB    = 2'd3
  } sched_state_e;

  localparam int DEF_REG_SIZE    = 384;
  localparam int DEF_REG_NUM     = 8;
  localparam int DEF_MULT_CYCLES = 40;
  localparam int DEF_ADD_CYCLES  = 4;

  // Width of the hold counter; it only ever holds (cycles - 1).
  function automatic int cnt_width(input int mult_cycles, input int add_cycles);
    int m;
    m = (mult_cycles > add_cycles) ? mult_cycles : add_cycles;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/ecc_fau_sched_regfile.sv
// ecc_fau_sched_regfile: operand register file with one shared write port
// (writeback has priority over the host), two combinational source reads,
// one registered host read and a synchronous clear.
module ecc_fau_sched_regfile #(
  parameter int REG_SIZE = 384,
  parameter int REG_NUM  = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       zeroize,
  input  logic                       wb_en,
  input  logic [$clog2(REG_NUM)-1:0] wb_addr,
  input  logic [REG_SIZE-1:0]        wb_data,
  input  logic                       wr_en,
  input  logic [$clog2(REG_NUM)-1:0] wr_addr,
  input  logic [REG_SIZE-1:0]        wr_data,
  input  logic [$clog2(REG_NUM)-1:0] ra_addr,
  input  logic [$clog2(REG_NUM)-1:0] rb_addr,
  output logic [REG_SIZE-1:0]        ra_data,
  output logic [REG_SIZE-1:0]        rb_data,
  input  logic [$clog2(REG_NUM)-1:0] rd_addr,
  output logic [REG_SIZE-1:0]        rd_data
);

  localparam int AW = $clog2(REG_NUM);

  logic [REG_SIZE-1:0] mem_reg [REG_NUM];
  logic [REG_SIZE-1:0] rd_data_reg;
  logic [REG_NUM-1:0]  wb_sel;
  logic [REG_NUM-1:0]  wr_sel;

  // Per-entry write decode; a host write loses to a writeback on the same entry.
  generate
    for (genvar gi = 0; gi < REG_NUM; gi++) begin : g_dec
      assign wb_sel[gi] = wb_en && (wb_addr == AW'(gi));
      assign wr_sel[gi] = wr_en && (wr_addr == AW'(gi)) && !wb_sel[gi];
    end
  endgenerate

  // Storage update, clear on reset/zeroize, registered host read (no bypass).
  always_ff @(posedge clk) begin
    if (!reset_n || zeroize) begin
      for (int i = 0; i < REG_NUM; i++) mem_reg[i] <= '0;
      rd_data_reg <= '0;
    end else begin
      for (int i = 0; i < REG_NUM; i++) begin
        if (wb_sel[i])      mem_reg[i] <= wb_data;
        else if (wr_sel[i]) mem_reg[i] <= wr_data;
      end
      rd_data_reg <= mem_reg[rd_addr];
    end
  end

  assign ra_data = mem_reg[ra_addr];
  assign rb_data = mem_reg[rb_addr];
  assign rd_data = rd_data_reg;

endmodule

// File: rtl/ecc_fau_sched.sv
// ecc_fau_sched: three-address command sequencer sharing one ECC FAU.
// Completion is timed by a hold counter since the FAU has no ready.
// Define ECC_FAU_SCHED_CMD_FIFO_EN to add a 2-entry command FIFO in front
// of the FSM so commands can be queued while an operation runs.
module ecc_fau_sched
  import ecc_fau_sched_pkg::*;
#(
  parameter int REG_SIZE    = DEF_REG_SIZE,
  parameter int REG_NUM     = DEF_REG_NUM,
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int ADD_CYCLES  = DEF_ADD_CYCLES
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       zeroize,
  input  logic                       cmd_valid_i,
  output logic                       cmd_ready_o,
  input  logic [1:0]                 cmd_op_i,
  input  logic [$clog2(REG_NUM)-1:0] cmd_dst_i,
  input  logic [$clog2(REG_NUM)-1:0] cmd_srca_i,
  input  logic [$clog2(REG_NUM)-1:0] cmd_srcb_i,
  output logic                       done_o,
  output logic                       busy_o,
  input  logic                       wr_en_i,
  input  logic [$clog2(REG_NUM)-1:0] wr_addr_i,
  input  logic [REG_SIZE-1:0]        wr_data_i,
  input  logic [$clog2(REG_NUM)-1:0] rd_addr_i,
  output logic [REG_SIZE-1:0]        rd_data_o,
  output logic                       fau_add_en_o,
  output logic                       fau_sub_o,
  output logic                       fau_mult_en_o,
  output logic [REG_SIZE-1:0]        fau_opa_o,
  output logic [REG_SIZE-1:0]        fau_opb_o,
  input  logic [REG_SIZE-1:0]        fau_add_res_i,
  input  logic [REG_SIZE-1:0]        fau_mult_res_i
);

  localparam int AW = $clog2(REG_NUM);
  localparam int CW = cnt_width(MULT_CYCLES, ADD_CYCLES);

  typedef struct packed {
    fau_op_e       op;
    logic [AW-1:0] dst;
    logic [AW-1:0] srca;
    logic [AW-1:0] srcb;
  } cmd_t;

  logic          clr;
  cmd_t          cmd_in;
  cmd_t          head;
  logic          cmd_avail;
  logic          cmd_take;
  logic          pending;

  sched_state_e  state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  fau_op_e       op_reg, op_next;
  logic [AW-1:0] dst_reg, dst_next;
  logic [REG_SIZE-1:0] opa_reg, opa_next;
  logic [REG_SIZE-1:0] opb_reg, opb_next;
  logic          add_en_reg, add_en_next;
  logic          mult_en_reg, mult_en_next;

  logic          wb_en;
  logic [REG_SIZE-1:0] wb_data;
  logic [REG_SIZE-1:0] ra_data;
  logic [REG_SIZE-1:0] rb_data;

  assign clr = !reset_n || zeroize;

  assign cmd_in.op   = fau_op_e'(cmd_op_i);
  assign cmd_in.dst  = cmd_dst_i;
  assign cmd_in.srca = cmd_srca_i;
  assign cmd_in.srcb = cmd_srcb_i;

`ifdef ECC_FAU_SCHED_CMD_FIFO_EN
  cmd_t       fifo_mem_reg [2];
  logic       fifo_wr_ptr_reg;
  logic       fifo_rd_ptr_reg;
  logic [1:0] fifo_count_reg;
  logic       fifo_push;

  assign fifo_push = cmd_valid_i && (fifo_count_reg != 2'd2);

  // Two-entry command queue; the FSM pops the head when it is idle.
  always_ff @(posedge clk) begin
    if (clr) begin
      fifo_mem_reg[0] <= '0;
      fifo_mem_reg[1] <= '0;
      fifo_wr_ptr_reg <= 1'b0;
      fifo_rd_ptr_reg <= 1'b0;
      fifo_count_reg  <= 2'd0;
    end else begin
      if (fifo_push) begin
        fifo_mem_reg[fifo_wr_ptr_reg] <= cmd_in;
        fifo_wr_ptr_reg <= ~fifo_wr_ptr_reg;
      end
      if (cmd_take) fifo_rd_ptr_reg <= ~fifo_rd_ptr_reg;
      fifo_count_reg <= fifo_count_reg + 2'(fifo_push) - 2'(cmd_take);
    end
  end

  assign cmd_avail   = (fifo_count_reg != 2'd0);
  assign head        = fifo_mem_reg[fifo_rd_ptr_reg];
  assign pending     = (fifo_count_reg != 2'd0);
  assign cmd_ready_o = !clr && (fifo_count_reg != 2'd2);
`else
  assign cmd_avail   = cmd_valid_i;
  assign head        = cmd_in;
  assign pending     = 1'b0;
  assign cmd_ready_o = !clr && (state_reg == ST_IDLE);
`endif

  // Sequencer state, operand latches and registered FAU enables.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      op_reg      <= FAU_ADD;
      dst_reg     <= '0;
      opa_reg     <= '0;
      opb_reg     <= '0;
      add_en_reg  <= 1'b0;
      mult_en_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      op_reg      <= op_next;
      dst_reg     <= dst_next;
      opa_reg     <= opa_next;
      opb_reg     <= opb_next;
      add_en_reg  <= add_en_next;
      mult_en_reg <= mult_en_next;
    end
  end

  // Next-state logic: enables are registered so they rise on entry to WAIT
  // and fall on entry to WB, giving exactly OP_CYCLES high cycles.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    op_next      = op_reg;
    dst_next     = dst_reg;
    opa_next     = opa_reg;
    opb_next     = opb_reg;
    add_en_next  = 1'b0;
    mult_en_next = 1'b0;
    wb_en        = 1'b0;
    cmd_take     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (cmd_avail) begin
          cmd_take = 1'b1;
          op_next  = head.op;
          dst_next = head.dst;
          if (head.op == FAU_NOP) begin
            // Reserved op: no FAU activity, just a done pulse.
            state_next = ST_WB;
          end else begin
            opa_next   = ra_data;
            opb_next   = rb_data;
            state_next = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (op_reg == FAU_MUL) begin
          mult_en_next = 1'b1;
          cnt_next     = CW'(MULT_CYCLES - 1);
        end else begin
          add_en_next  = 1'b1;
          cnt_next     = CW'(ADD_CYCLES - 1);
        end
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_reg == '0) begin
          state_next = ST_WB;
        end else begin
          cnt_next     = cnt_reg - 1'b1;
          add_en_next  = add_en_reg;
          mult_en_next = mult_en_reg;
        end
      end
      ST_WB: begin
        wb_en      = (op_reg != FAU_NOP);
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign wb_data = (op_reg == FAU_MUL) ? fau_mult_res_i : fau_add_res_i;

  ecc_fau_sched_regfile #(
    .REG_SIZE (REG_SIZE),
    .REG_NUM  (REG_NUM)
  ) u_regfile (
    .clk     (clk),
    .reset_n (reset_n),
    .zeroize (zeroize),
    .wb_en   (wb_en),
    .wb_addr (dst_reg),
    .wb_data (wb_data),
    .wr_en   (wr_en_i),
    .wr_addr (wr_addr_i),
    .wr_data (wr_data_i),
    .ra_addr (head.srca),
    .rb_addr (head.srcb),
    .ra_data (ra_data),
    .rb_data (rb_data),
    .rd_addr (rd_addr_i),
    .rd_data (rd_data_o)
  );

  assign done_o        = !clr && (state_reg == ST_WB);
  assign busy_o        = !clr && ((state_reg != ST_IDLE) || pending);
  assign fau_add_en_o  = add_en_reg;
  assign fau_mult_en_o = mult_en_reg;
  assign fau_sub_o     = (op_reg == FAU_SUB);
  assign fau_opa_o     = opa_reg;
  assign fau_opb_o     = opb_reg;

endmodule

// File: tb/tb_ecc_fau_sched.sv
// tb_ecc_fau_sched: directed test of the FAU sequencer against a small
// behavioural FAU over p = 65521 with 16-bit operands (R mod p = 15).
module tb_ecc_fau_sched;

  localparam int W  = 16;
  localparam int RN = 8;
  localparam int MC = 40;
  localparam int AC = 4;
  localparam logic [W-1:0] P     = 16'd65521;
  localparam logic [W-1:0] R_MOD = 16'd15;
  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_NOP = 2'd3;
`ifdef ECC_FAU_SCHED_CMD_FIFO_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic         clk = 1'b0;
  logic         reset_n, zeroize;
  logic         cmd_valid, cmd_ready;
  logic [1:0]   cmd_op;
  logic [2:0]   cmd_dst, cmd_srca, cmd_srcb;
  logic         done, busy;
  logic         wr_en;
  logic [2:0]   wr_addr, rd_addr;
  logic [W-1:0] wr_data, rd_data;
  logic         add_en, sub_sel, mult_en;
  logic [W-1:0] opa, opb, add_res, mult_res;

  int checks = 0;
  int errors = 0;
  int gap_viol = 0;
  int done_cnt = 0;
  logic prev_add = 1'b0;
  logic prev_mult = 1'b0;

  ecc_fau_sched #(
    .REG_SIZE    (W),
    .REG_NUM     (RN),
    .MULT_CYCLES (MC),
    .ADD_CYCLES  (AC)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .zeroize        (zeroize),
    .cmd_valid_i    (cmd_valid),
    .cmd_ready_o    (cmd_ready),
    .cmd_op_i       (cmd_op),
    .cmd_dst_i      (cmd_dst),
    .cmd_srca_i     (cmd_srca),
    .cmd_srcb_i     (cmd_srcb),
    .done_o         (done),
    .busy_o         (busy),
    .wr_en_i        (wr_en),
    .wr_addr_i      (wr_addr),
    .wr_data_i      (wr_data),
    .rd_addr_i      (rd_addr),
    .rd_data_o      (rd_data),
    .fau_add_en_o   (add_en),
    .fau_sub_o      (sub_sel),
    .fau_mult_en_o  (mult_en),
    .fau_opa_o      (opa),
    .fau_opb_o      (opb),
    .fau_add_res_i  (add_res),
    .fau_mult_res_i (mult_res)
  );

  always #5 clk = ~clk;

  // Behavioural FAU: modular add/sub and bit-serial Montgomery multiply.
  function automatic logic [W-1:0] mod_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, P}) s = s - {1'b0, P};
    return s[W-1:0];
  endfunction

  function automatic logic [W-1:0] mod_sub(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    if (a >= b) s = {1'b0, a} - {1'b0, b};
    else        s = {1'b0, a} + {1'b0, P} - {1'b0, b};
    return s[W-1:0];
  endfunction

  function automatic logic [W-1:0] mont(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W:0] t;
    t = {{(W+1){1'b0}}, a} * {{(W+1){1'b0}}, b};
    for (int i = 0; i < W; i++) begin
      if (t[0]) t = t + {{(W+1){1'b0}}, P};
      t = t >> 1;
    end
    if (t >= {{(W+1){1'b0}}, P}) t = t - {{(W+1){1'b0}}, P};
    return t[W-1:0];
  endfunction

  assign add_res  = sub_sel ? mod_sub(opa, opb) : mod_add(opa, opb);
  assign mult_res = mont(opa, opb);

  // Enable-gap and done-pulse monitor, sampled on the falling edge.
  always @(negedge clk) begin
    prev_add  <= add_en;
    prev_mult <= mult_en;
    if (((add_en && !prev_add) || (mult_en && !prev_mult)) && (prev_add || prev_mult))
      gap_viol <= gap_viol + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [2:0] a, input logic [W-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic host_read(input logic [2:0] a, output logic [W-1:0] d);
    rd_addr = a;
    tick();
    d = rd_data;
  endtask

  // Issue one command and follow it to its done pulse; optionally collide a
  // host write with the writeback cycle.
  task automatic run_cmd(input logic [1:0] op, input logic [2:0] dst,
                         input logic [2:0] sa, input logic [2:0] sb,
                         input logic clash, input logic [W-1:0] clash_data,
                         output int lat, output int wait_n, output int add_n,
                         output int mult_n, output int sub_n);
    int k;
    lat = 0; wait_n = 0; add_n = 0; mult_n = 0; sub_n = 0;
    cmd_op = op; cmd_dst = dst; cmd_srca = sa; cmd_srcb = sb; cmd_valid = 1'b1;
    while (!cmd_ready && wait_n < 500) begin
      tick();
      wait_n++;
    end
    if (wait_n >= 500) check("ready_timeout", 0, 1);
    tick();
    cmd_valid = 1'b0;
    for (k = 1; k <= 300; k++) begin
      if (add_en) add_n++;
      if (mult_en) mult_n++;
      if (add_en && sub_sel) sub_n++;
      if (done) begin
        lat = k;
        if (clash) begin
          wr_en = 1'b1; wr_addr = dst; wr_data = clash_data;
        end
        break;
      end
      tick();
    end
    if (lat == 0) check("done_timeout", 0, 1);
    tick();
    wr_en = 1'b0;
    $display("cmd op=%0d dst=%0d srca=%0d srcb=%0d latency=%0d add_en=%0d mult_en=%0d",
             op, dst, sa, sb, lat, add_n, mult_n);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] rv;
    int lat, wn, an, mn, sn, d0, k;

    reset_n = 1'b0; zeroize = 1'b0; cmd_valid = 1'b0; cmd_op = '0;
    cmd_dst = '0; cmd_srca = '0; cmd_srcb = '0; wr_en = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr = '0;

    // Reset state
    tick(); tick();
    check("rst_ready", cmd_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_en", {add_en, mult_en, sub_sel}, 0);
    check("rst_opa", opa, 0);
    reset_n = 1'b1;
    #1;
    check("idle_ready", cmd_ready, 1);
    host_read(3'd0, rv);
    check("rst_r0", rv, 0);

    // ADD 5 + 7
    host_write(3'd0, 16'd5);
    host_write(3'd1, 16'd7);
    run_cmd(OP_ADD, 3'd2, 3'd0, 3'd1, 1'b0, '0, lat, wn, an, mn, sn);
    check("add_latency", lat, AC + 2 + EXTRA);
    check("add_en_cycles", an, AC);
    check("add_mult_cycles", mn, 0);
    host_read(3'd2, rv);
    check("add_result", rv, 12);

    // SUB 5 - 7 wraps to p - 2
    run_cmd(OP_SUB, 3'd3, 3'd0, 3'd1, 1'b0, '0, lat, wn, an, mn, sn);
    check("sub_latency", lat, AC + 2 + EXTRA);
    check("sub_sel_cycles", sn, AC);
    host_read(3'd3, rv);
    check("sub_result", rv, 65519);

    // MUL (Montgomery one) * 9 = 9
    host_write(3'd0, R_MOD);
    host_write(3'd1, 16'd9);
    run_cmd(OP_MUL, 3'd4, 3'd0, 3'd1, 1'b0, '0, lat, wn, an, mn, sn);
    check("mul_latency", lat, MC + 2 + EXTRA);
    check("mul_en_cycles", mn, MC);
    check("mul_add_cycles", an, 0);
    host_read(3'd4, rv);
    check("mul_result", rv, 9);

    // Reserved op: done one cycle later, no FAU activity, no writeback
    run_cmd(OP_NOP, 3'd7, 3'd0, 3'd1, 1'b0, '0, lat, wn, an, mn, sn);
    check("nop_latency", lat, 1 + EXTRA);
    check("nop_enables", an + mn, 0);
    host_read(3'd7, rv);
    check("nop_no_wb", rv, 0);

    // Back-to-back: in-place ADD then MUL consuming the updated register
    host_write(3'd0, 16'd5);
    host_write(3'd1, 16'd7);
    host_write(3'd6, R_MOD);
    run_cmd(OP_ADD, 3'd0, 3'd0, 3'd1, 1'b0, '0, lat, wn, an, mn, sn);
    check("b2b_add_latency", lat, AC + 2 + EXTRA);
    run_cmd(OP_MUL, 3'd5, 3'd0, 3'd6, 1'b0, '0, lat, wn, an, mn, sn);
    check("b2b_no_wait", wn, 0);
    check("b2b_mul_latency", lat, MC + 2 + EXTRA);
    host_read(3'd5, rv);
    check("b2b_mul_result", rv, 12);
    host_read(3'd0, rv);
    check("inplace_result", rv, 12);

    // Zeroize in the WAIT window of a MUL
    cmd_op = OP_MUL; cmd_dst = 3'd4; cmd_srca = 3'd0; cmd_srcb = 3'd6; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    repeat (10) tick();
    check("zz_mult_active", mult_en, 1);
    check("zz_busy", busy, 1);
`ifndef ECC_FAU_SCHED_CMD_FIFO_EN
    check("zz_not_ready", cmd_ready, 0);
`endif
    d0 = done_cnt;
    zeroize = 1'b1;
    tick();
    zeroize = 1'b0;
    check("zz_enables_low", {add_en, mult_en}, 0);
    check("zz_busy_low", busy, 0);
    repeat (MC + 5) tick();
    check("zz_no_done", done_cnt - d0, 0);
    for (int i = 0; i < RN; i++) begin
      host_read(3'(i), rv);
      check($sformatf("zz_reg%0d", i), rv, 0);
    end
    host_write(3'd0, 16'd5);
    host_write(3'd1, 16'd7);
    run_cmd(OP_ADD, 3'd2, 3'd0, 3'd1, 1'b0, '0, lat, wn, an, mn, sn);
    check("zz_add_latency", lat, AC + 2 + EXTRA);
    host_read(3'd2, rv);
    check("zz_add_result", rv, 12);

    // Host write colliding with writeback: writeback wins
    run_cmd(OP_SUB, 3'd2, 3'd1, 3'd0, 1'b1, 16'h1234, lat, wn, an, mn, sn);
    host_read(3'd2, rv);
    check("wb_priority", rv, 2);

`ifdef ECC_FAU_SCHED_CMD_FIFO_EN
    // Two commands queued while a MUL runs complete in order
    host_write(3'd0, R_MOD);
    host_write(3'd6, 16'd0);
    host_write(3'd7, 16'd0);
    d0 = done_cnt;
    cmd_op = OP_MUL; cmd_dst = 3'd4; cmd_srca = 3'd0; cmd_srcb = 3'd1; cmd_valid = 1'b1;
    tick();
    cmd_op = OP_ADD; cmd_dst = 3'd6;
    tick();
    check("fifo_busy", busy, 1);
    check("fifo_ready2", cmd_ready, 1);
    cmd_op = OP_SUB; cmd_dst = 3'd7;
    tick();
    cmd_valid = 1'b0;
    for (k = 0; k < 400 && (done_cnt - d0) < 3; k++) tick();
    check("fifo_done_count", done_cnt - d0, 3);
    tick();
    host_read(3'd4, rv);
    check("fifo_mul", rv, 7);
    host_read(3'd6, rv);
    check("fifo_add", rv, 22);
    host_read(3'd7, rv);
    check("fifo_sub", rv, 8);
    $display("fifo queued ADD and SUB behind MUL in %0d cycles", k);
`endif

    repeat (3) tick();
    check("enable_gap", gap_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
